nkmd_ddr3_arb: RTL and testbench
================================

# nkmd_ddr3_arb

Two-requester arbiter that shares one MIG DDR3 user port (32-bit, cmd/wr/rd FIFOs) between the nkmd CPU DDR3 bridge (requester 0) and the audio DMA engine (requester 1). It accepts one burst command at a time, streams write beats into the MIG write FIFO, then issues the MIG command. For reads, it pops the MIG read FIFO and routes the data to the granted requester. Grants alternate round-robin, so neither side starves.

## Interface
Parameters:
- `PRIO1`, default 0: when 1, requester 1 always wins a tie (no round-robin).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  (N=0,1) command request; held until `reqN_ready`.
- `reqN_ready`  out  1  command accepted this cycle.
- `reqN_we`  in  1  1=write, 0=read.
- `reqN_addr`  in  30  DDR3 byte address; bits [1:0] are ignored (forced 0).
- `reqN_bl`  in  6  burst length minus 1, in words (0..63 → 1..64 words).
- `reqN_wdata`  in  32  write beat.
- `reqN_wvalid`  in  1  write beat valid.
- `reqN_wready`  out  1  write beat taken.
- `rd_data`  out  32  registered read word, shared by both requesters.
- `reqN_rvalid`  out  1  `rd_data` belongs to requester N; no backpressure.
- `reqN_done`  out  1  one-cycle pulse at the end of the transaction.
- `busy`  out  1  state != IDLE.
- `mig_cmd_en`, `mig_cmd_instr`[2:0], `mig_cmd_bl`[5:0], `mig_cmd_byte_addr`[29:0]  out  MIG command port.
- `mig_cmd_full`  in  1  MIG command FIFO full.
- `mig_wr_en`, `mig_wr_data`[31:0], `mig_wr_mask`[3:0]  out  MIG write port; `mig_wr_mask` is constant 0.
- `mig_wr_full`  in  1  MIG write FIFO full.
- `mig_rd_en`  out  1  MIG read FIFO pop.
- `mig_rd_data`  in  32  MIG read word.
- `mig_rd_empty`  in  1  MIG read FIFO empty.

## Operation
- State machine: IDLE, WDATA, CMD, RDATA, DONE.
- **IDLE:** the winner is computed combinationally.
  - Single valid: that requester wins.
  - Both valid: with `PRIO1`=0, the requester not granted last wins; with `PRIO1`=1, requester 1 wins.
  - `reqW_ready`=1 in the winning cycle. `we`, `addr` (with [1:0] zeroed) and `bl` are latched, the grant index `g` is stored, and `last` := W.
  - Next state: WDATA if `we`, else CMD.
- **WDATA:**
  - `reqg_wready` = `!mig_wr_full`.
  - `mig_wr_en` = `reqg_wvalid & reqg_wready`, with `mig_wr_data` = `reqg_wdata` passed through combinationally.
  - Beat counter increments on each `mig_wr_en`. On beat `bl`+1, go to CMD.
  - The other requester's `wready` is always 0.
- **CMD:**
  - `mig_cmd_en` = `!mig_cmd_full`.
  - `mig_cmd_instr` = 3'b000 for write, 3'b001 for read. `mig_cmd_bl` and `mig_cmd_byte_addr` come from the latched values, held stable throughout CMD.
  - On `mig_cmd_en`: write goes to DONE, read goes to RDATA (counter cleared).
- **RDATA:**
  - `mig_rd_en` = `!mig_rd_empty`.
  - Each pop registers `rd_data` <= `mig_rd_data` and sets `reqg_rvalid` for exactly the next cycle.
  - After `bl`+1 pops, go to DONE.
- **DONE:** `reqg_done`=1 for one cycle, then IDLE. No request is accepted in DONE.
- Boundary conditions:
  - Write beats offered by the other requester are never taken.
  - `mig_rd_count` is unused; pops are gated only by `mig_rd_empty`.
  - Extra read words beyond `bl`+1 are left in the FIFO.
  - `bl`=63 needs the full 6-bit compare, with the counter 7 bits wide.
- Reset (async, any state):
  - State IDLE, `last` := 1 (so requester 0 wins the first tie), counters 0, `rd_data` 0.
  - All outputs 0, including `reqN_ready`, `wready`, `rvalid`, `done`, `busy`, `mig_cmd_en`, `mig_wr_en`, `mig_rd_en`.
  - An in-flight transaction is dropped without a done pulse.

## Timing
- Command acceptance: same cycle as `valid` when IDLE. `ready` is a one-cycle pulse, combinational from `valid` and state.
- Minimum write, no stalls, `bl`=0: 4 cycles (IDLE accept, WDATA beat, CMD, DONE).
- Minimum read, FIFO non-empty: IDLE, CMD, RDATA × (`bl`+1), DONE.
  - `rvalid` lags each `mig_rd_en` by 1 cycle. The last `rvalid` coincides with DONE, which also carries `done`.
- `mig_wr_full`, `mig_cmd_full` and `mig_rd_empty` stall their state indefinitely. No timeout.
- Back-to-back: the next grant is possible in the first IDLE cycle after DONE. Throughput is therefore one transaction per (length + 3) cycles for writes.

## Test plan
- Single write: req0 `addr`=0x0abcdefe, `bl`=7, beats 1..8, no stalls → 8 `mig_wr_en` with data 1..8, then one `mig_cmd_en` with `instr`=000, `bl`=7, `addr`=0x0abcdefc, then a `req0_done` pulse.
- Single read: req1 `addr`=0x2dadadac, `bl`=1, MIG FIFO delivers 0xdeadbeef then 0xcafebabe with a 3-cycle empty gap → `req1_rvalid` twice with those values, `req0_rvalid` stays 0, `done` on the second `rvalid`.
- Tie round-robin: both valid continuously, `bl`=0 reads → grants 0,1,0,1. With `PRIO1`=1 → grants 1,1,1.
- Stalls: `mig_wr_full` high for 5 cycles mid-burst, then `mig_cmd_full` high 3 cycles → no beat lost or duplicated, `mig_cmd_en` is asserted only once `mig_cmd_full`=0, command fields stable throughout.
- `bl`=63 write → exactly 64 beats, then the command with `bl`=63.
- `rst_n` low during RDATA → all outputs 0 immediately. After release, an idle tie grants requester 0.

Source files
------------

// File: rtl/nkmd_ddr3_arb.sv
// nkmd_ddr3_arb: two-requester arbiter in front of one 32-bit MIG DDR3 user port.
//   Requester 0 is the CPU DDR3 bridge and requester 1 is the audio DMA engine.
//   One burst is in flight at a time. Writes stream their beats into the MIG
//   write FIFO before the command is issued. Reads issue the command, then pop
//   the read FIFO and route each word to the granted requester.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/we/addr/bl      command handshake (N = 0, 1)
//   reqN_wdata/wvalid/wready         write beats
//   rd_data, reqN_rvalid             registered read word and its owner
//   reqN_done                        end-of-transaction pulse
//   busy                             arbiter not idle
//   mig_cmd_*, mig_wr_*, mig_rd_*    MIG user port
module nkmd_ddr3_arb #(
    parameter bit PRIO1 = 1'b0          // 1: requester 1 always wins a tie
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [29:0] req0_addr,
    input  logic [5:0]  req0_bl,
    input  logic [31:0] req0_wdata,
    input  logic        req0_wvalid,
    output logic        req0_wready,
    output logic        req0_rvalid,
    output logic        req0_done,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [29:0] req1_addr,
    input  logic [5:0]  req1_bl,
    input  logic [31:0] req1_wdata,
    input  logic        req1_wvalid,
    output logic        req1_wready,
    output logic        req1_rvalid,
    output logic        req1_done,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        mig_cmd_en,
    output logic [2:0]  mig_cmd_instr,
    output logic [5:0]  mig_cmd_bl,
    output logic [29:0] mig_cmd_byte_addr,
    input  logic        mig_cmd_full,
    output logic        mig_wr_en,
    output logic [31:0] mig_wr_data,
    output logic [3:0]  mig_wr_mask,
    input  logic        mig_wr_full,
    output logic        mig_rd_en,
    input  logic [31:0] mig_rd_data,
    input  logic        mig_rd_empty
);
    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_CMD, S_RDATA, S_DONE} state_t;

    state_t      state, nstate;
    logic        g;             // granted requester
    logic        last;          // requester granted most recently
    logic        we_q;
    logic [29:0] addr_q;
    logic [5:0]  bl_q;
    logic [6:0]  cnt;           // 7 bits: reaches 64 after a bl=63 burst
    logic [1:0]  rvalid_q;

    logic        win, accept;
    logic        sel_we;
    logic [29:0] sel_addr;
    logic [5:0]  sel_bl;
    logic        wvalid_g;
    logic [31:0] wdata_g;
    logic        last_beat;

    // Tie: fixed priority to 1, or the side that did not win last time.
    assign win      = (req0_valid & req1_valid) ? (PRIO1 ? 1'b1 : ~last) : req1_valid;
    assign sel_we   = win ? req1_we   : req0_we;
    assign sel_addr = win ? req1_addr : req0_addr;
    assign sel_bl   = win ? req1_bl   : req0_bl;
    assign wvalid_g = g ? req1_wvalid : req0_wvalid;
    assign wdata_g  = g ? req1_wdata  : req0_wdata;
    assign last_beat = (cnt == {1'b0, bl_q});

    assign busy              = (state != S_IDLE);
    assign mig_wr_mask       = 4'b0000;
    assign mig_cmd_instr     = (state == S_CMD && !we_q) ? 3'b001 : 3'b000;
    assign mig_cmd_bl        = bl_q;
    assign mig_cmd_byte_addr = addr_q;
    assign req0_rvalid       = rvalid_q[0];
    assign req1_rvalid       = rvalid_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate      = state;
        accept      = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        req0_wready = 1'b0;
        req1_wready = 1'b0;
        req0_done   = 1'b0;
        req1_done   = 1'b0;
        mig_cmd_en  = 1'b0;
        mig_wr_en   = 1'b0;
        mig_wr_data = 32'h0;
        mig_rd_en   = 1'b0;
        case (state)
            S_IDLE: begin
                // ready is combinational from valid, so hold it off while in reset
                if ((req0_valid | req1_valid) && rst_n) begin
                    accept     = 1'b1;
                    req0_ready = ~win;
                    req1_ready = win;
                    nstate     = sel_we ? S_WDATA : S_CMD;
                end
            end
            S_WDATA: begin
                req0_wready = ~g & ~mig_wr_full;
                req1_wready =  g & ~mig_wr_full;
                mig_wr_en   = wvalid_g & ~mig_wr_full;
                mig_wr_data = wdata_g;
                if (mig_wr_en && last_beat) nstate = S_CMD;
            end
            S_CMD: begin
                mig_cmd_en = ~mig_cmd_full;
                if (!mig_cmd_full) nstate = we_q ? S_DONE : S_RDATA;
            end
            S_RDATA: begin
                mig_rd_en = ~mig_rd_empty;
                if (!mig_rd_empty && last_beat) nstate = S_DONE;
            end
            S_DONE: begin
                req0_done = ~g;
                req1_done = g;
                nstate    = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g        <= 1'b0;
            last     <= 1'b1;   // requester 0 wins the first tie
            we_q     <= 1'b0;
            addr_q   <= 30'h0;
            bl_q     <= 6'h0;
            cnt      <= 7'h0;
            rd_data  <= 32'h0;
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= 2'b00;
            if (accept) begin
                g      <= win;
                last   <= win;
                we_q   <= sel_we;
                addr_q <= sel_addr & ~30'h3;
                bl_q   <= sel_bl;
                cnt    <= 7'h0;
            end
            if (mig_wr_en) cnt <= cnt + 7'd1;
            if (state == S_CMD) cnt <= 7'h0;
            if (mig_rd_en) begin
                cnt         <= cnt + 7'd1;
                rd_data     <= mig_rd_data;
                rvalid_q[g] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nkmd_ddr3_arb.sv
module tb_nkmd_ddr3_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid = 0, req0_we = 0, req0_wvalid = 0;
    logic        req1_valid = 0, req1_we = 0, req1_wvalid = 0;
    logic [29:0] req0_addr = 0, req1_addr = 0;
    logic [5:0]  req0_bl = 0, req1_bl = 0;
    logic [31:0] req0_wdata = 0, req1_wdata = 0, mig_rd_data = 0;
    logic        mig_cmd_full = 0, mig_wr_full = 0, mig_rd_empty = 1;

    logic        req0_ready, req1_ready, req0_wready, req1_wready;
    logic        req0_rvalid, req1_rvalid, req0_done, req1_done, busy;
    logic [31:0] rd_data, mig_wr_data;
    logic        mig_cmd_en, mig_wr_en, mig_rd_en;
    logic [2:0]  mig_cmd_instr;
    logic [5:0]  mig_cmd_bl;
    logic [29:0] mig_cmd_byte_addr;
    logic [3:0]  mig_wr_mask;

    logic        p_req0_ready, p_req1_ready, p_req0_wready, p_req1_wready;
    logic        p_req0_rvalid, p_req1_rvalid, p_req0_done, p_req1_done, p_busy;
    logic [31:0] p_rd_data, p_mig_wr_data;
    logic        p_mig_cmd_en, p_mig_wr_en, p_mig_rd_en;
    logic [2:0]  p_mig_cmd_instr;
    logic [5:0]  p_mig_cmd_bl;
    logic [29:0] p_mig_cmd_byte_addr;
    logic [3:0]  p_mig_wr_mask;

    nkmd_ddr3_arb #(.PRIO1(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_bl(req0_bl), .req0_wdata(req0_wdata),
        .req0_wvalid(req0_wvalid), .req0_wready(req0_wready),
        .req0_rvalid(req0_rvalid), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_bl(req1_bl), .req1_wdata(req1_wdata),
        .req1_wvalid(req1_wvalid), .req1_wready(req1_wready),
        .req1_rvalid(req1_rvalid), .req1_done(req1_done),
        .rd_data(rd_data), .busy(busy),
        .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr), .mig_cmd_bl(mig_cmd_bl),
        .mig_cmd_byte_addr(mig_cmd_byte_addr), .mig_cmd_full(mig_cmd_full),
        .mig_wr_en(mig_wr_en), .mig_wr_data(mig_wr_data), .mig_wr_mask(mig_wr_mask),
        .mig_wr_full(mig_wr_full), .mig_rd_en(mig_rd_en), .mig_rd_data(mig_rd_data),
        .mig_rd_empty(mig_rd_empty)
    );

    // Same stimulus, fixed priority to requester 1.
    nkmd_ddr3_arb #(.PRIO1(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(p_req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_bl(req0_bl), .req0_wdata(req0_wdata),
        .req0_wvalid(req0_wvalid), .req0_wready(p_req0_wready),
        .req0_rvalid(p_req0_rvalid), .req0_done(p_req0_done),
        .req1_valid(req1_valid), .req1_ready(p_req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_bl(req1_bl), .req1_wdata(req1_wdata),
        .req1_wvalid(req1_wvalid), .req1_wready(p_req1_wready),
        .req1_rvalid(p_req1_rvalid), .req1_done(p_req1_done),
        .rd_data(p_rd_data), .busy(p_busy),
        .mig_cmd_en(p_mig_cmd_en), .mig_cmd_instr(p_mig_cmd_instr), .mig_cmd_bl(p_mig_cmd_bl),
        .mig_cmd_byte_addr(p_mig_cmd_byte_addr), .mig_cmd_full(mig_cmd_full),
        .mig_wr_en(p_mig_wr_en), .mig_wr_data(p_mig_wr_data), .mig_wr_mask(p_mig_wr_mask),
        .mig_wr_full(mig_wr_full), .mig_rd_en(p_mig_rd_en), .mig_rd_data(mig_rd_data),
        .mig_rd_empty(mig_rd_empty)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // ---- reset state (valid held high to show ready is suppressed)
        req0_valid = 1; req1_valid = 1;
        #12;
        chk("rst_ready0", {31'b0, req0_ready}, 0);
        chk("rst_ready1", {31'b0, req1_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mig_en", {29'b0, mig_cmd_en, mig_wr_en, mig_rd_en}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mask", {28'b0, mig_wr_mask}, 0);
        req0_valid = 0; req1_valid = 0;
        tick(); rst_n = 1;

        // ---- single write, req0, bl=7; req1 offers beats that must be ignored
        tick();
        req0_valid = 1; req0_we = 1; req0_addr = 30'h0abcdefe; req0_bl = 7;
        req1_wvalid = 1; req1_wdata = 32'hbad0bad0;
        #1 chk("w_ready0", {31'b0, req0_ready}, 1);
        chk("w_ready1", {31'b0, req1_ready}, 0);
        for (int i = 0; i < 8; i++) begin
            tick(); req0_valid = 0; req0_wvalid = 1; req0_wdata = i + 1;
            #1 chk("w_wr_en", {31'b0, mig_wr_en}, 1);
            chk("w_wr_data", mig_wr_data, i + 1);
            chk("w_wready1", {30'b0, req0_wready, req1_wready}, 2'b10);
        end
        tick(); req0_wdata = 32'h99;
        #1 chk("w_cmd_en", {31'b0, mig_cmd_en}, 1);
        chk("w_no_extra_beat", {31'b0, mig_wr_en}, 0);
        chk("w_instr", {29'b0, mig_cmd_instr}, 0);
        chk("w_cmd_bl", {26'b0, mig_cmd_bl}, 7);
        chk("w_cmd_addr", {2'b0, mig_cmd_byte_addr}, 32'h0abcdefc);
        tick(); req0_wvalid = 0; req1_wvalid = 0;
        #1 chk("w_done", {30'b0, req0_done, req1_done}, 2'b10);
        chk("w_done_busy", {31'b0, busy}, 1);
        tick();
        #1 chk("w_idle", {29'b0, busy, req0_done, mig_cmd_en}, 0);

        // ---- single read, req1, bl=1, with a 3-cycle empty gap
        tick(); req1_valid = 1; req1_we = 0; req1_addr = 30'h2dadadac; req1_bl = 1;
        #1 chk("r_ready1", {30'b0, req0_ready, req1_ready}, 2'b01);
        tick(); req1_valid = 0;
        #1 chk("r_cmd_en", {31'b0, mig_cmd_en}, 1);
        chk("r_instr", {29'b0, mig_cmd_instr}, 1);
        chk("r_cmd_bl", {26'b0, mig_cmd_bl}, 1);
        chk("r_cmd_addr", {2'b0, mig_cmd_byte_addr}, 32'h2dadadac);
        tick(); mig_rd_empty = 0; mig_rd_data = 32'hdeadbeef;
        #1 chk("r_rd_en0", {31'b0, mig_rd_en}, 1);
        chk("r_rvalid_early", {30'b0, req0_rvalid, req1_rvalid}, 0);
        tick(); mig_rd_empty = 1; mig_rd_data = 32'h0;
        #1 chk("r_rvalid_a", {30'b0, req0_rvalid, req1_rvalid}, 2'b01);
        chk("r_data_a", rd_data, 32'hdeadbeef);
        chk("r_gap_rd_en", {31'b0, mig_rd_en}, 0);
        tick();
        #1 chk("r_gap_rvalid", {30'b0, req0_rvalid, req1_rvalid}, 0);
        tick();
        #1 chk("r_gap_busy", {31'b0, busy}, 1);
        tick(); mig_rd_empty = 0; mig_rd_data = 32'hcafebabe;
        #1 chk("r_rd_en1", {31'b0, mig_rd_en}, 1);
        tick();
        #1 chk("r_rvalid_b", {30'b0, req0_rvalid, req1_rvalid}, 2'b01);
        chk("r_data_b", rd_data, 32'hcafebabe);
        chk("r_done", {30'b0, req0_done, req1_done}, 2'b01);
        chk("r_no_extra_pop", {31'b0, mig_rd_en}, 0);
        tick(); mig_rd_empty = 1;
        #1 chk("r_idle", {31'b0, busy}, 0);

        // ---- tie round-robin, bl=0 reads; PRIO1 instance always grants 1
        mig_rd_data = 32'h5a5a5a5a;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                req0_valid = 1; req0_we = 0; req0_bl = 0; req0_addr = 30'h40;
                req1_valid = 1; req1_we = 0; req1_bl = 0; req1_addr = 30'h80;
                mig_rd_empty = 0;
            end
            #1 chk("tie_grant", {30'b0, req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("tie_prio1_grant", {30'b0, p_req1_ready, p_req0_ready}, 2'b10);
            tick();
            #1 chk("tie_cmd_addr", {2'b0, mig_cmd_byte_addr}, (k % 2 == 0) ? 32'h40 : 32'h80);
            tick();
            #1 chk("tie_rd_en", {31'b0, mig_rd_en}, 1);
            tick();
            #1 chk("tie_no_ready_in_done", {30'b0, req1_ready, req0_ready}, 0);
            chk("tie_done", {30'b0, req1_done, req0_done}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 3) begin req0_valid = 0; req1_valid = 0; mig_rd_empty = 1; end
        end

        // ---- write stalls: wr_full 5 cycles mid-burst, then cmd_full 3 cycles
        tick(); req0_valid = 1; req0_we = 1; req0_bl = 3; req0_addr = 30'h00000103;
        #1 chk("s_ready0", {31'b0, req0_ready}, 1);
        for (int i = 0; i < 2; i++) begin
            tick(); req0_valid = 0; req0_wvalid = 1; req0_wdata = 32'ha0 + i;
            #1 chk("s_beat", {31'b0, mig_wr_en}, 1);
            chk("s_beat_data", mig_wr_data, 32'ha0 + i);
        end
        for (int i = 0; i < 5; i++) begin
            tick(); mig_wr_full = 1; req0_wdata = 32'ha2;
            #1 chk("s_stall", {30'b0, mig_wr_en, req0_wready}, 0);
        end
        for (int i = 2; i < 4; i++) begin
            tick(); mig_wr_full = 0; req0_wdata = 32'ha0 + i;
            #1 chk("s_beat_data2", {mig_wr_data[30:0], mig_wr_en}, {31'ha0 + i, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            tick(); mig_cmd_full = 1;
            #1 chk("s_cmd_held", {29'b0, mig_cmd_en, mig_wr_en, busy}, 3'b001);
            chk("s_cmd_fields", {mig_cmd_bl, mig_cmd_byte_addr[25:0]}, {6'd3, 26'h100});
        end
        tick(); mig_cmd_full = 0; req0_wvalid = 0;
        #1 chk("s_cmd_en", {31'b0, mig_cmd_en}, 1);
        chk("s_cmd_addr", {2'b0, mig_cmd_byte_addr}, 32'h100);
        tick();
        #1 chk("s_done", {31'b0, req0_done}, 1);

        // ---- bl=63 write: exactly 64 beats
        tick(); req0_valid = 1; req0_we = 1; req0_bl = 63; req0_addr = 30'h1000;
        #1 chk("l_ready0", {31'b0, req0_ready}, 1);
        for (int i = 0; i < 64; i++) begin
            tick(); req0_valid = 0; req0_wvalid = 1; req0_wdata = 32'h1000 + i;
            #1 chk("l_beat", {mig_wr_data[30:0], mig_wr_en}, {31'h1000 + i, 1'b1});
        end
        tick();
        #1 chk("l_cmd", {mig_cmd_en, mig_wr_en, mig_cmd_bl}, {1'b1, 1'b0, 6'd63});
        tick(); req0_wvalid = 0;
        #1 chk("l_done", {31'b0, req0_done}, 1);

        // ---- reset during RDATA
        tick(); req0_valid = 1; req0_we = 0; req0_bl = 3; req0_addr = 30'h200;
        #1 chk("x_ready0", {31'b0, req0_ready}, 1);
        tick(); req0_valid = 0;
        tick(); mig_rd_empty = 0; mig_rd_data = 32'h11111111;
        #1 chk("x_rd_en", {31'b0, mig_rd_en}, 1);
        tick(); req0_valid = 1; req1_valid = 1;
        #1 chk("x_rvalid_before", {31'b0, req0_rvalid}, 1);
        rst_n = 0;
        #1 chk("x_rst_outs", {26'b0, busy, req0_rvalid, mig_rd_en, req0_done, req0_ready, req1_ready}, 0);
        chk("x_rst_rd_data", rd_data, 0);
        tick(); rst_n = 1; mig_rd_empty = 1;
        #1 chk("x_tie_after_rst", {30'b0, req1_ready, req0_ready}, 2'b01);
        chk("x_prio1_after_rst", {30'b0, p_req1_ready, p_req0_ready}, 2'b10);
        tick(); req0_valid = 0; req1_valid = 0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
